// File: rtl/t03_hwclk_pkg.sv
// Shared register map, CTRL bit positions and CTRL image type for the
// hardware-clock MMIO write side.
package t03_hwclk_pkg;

  localparam logic [3:0] OFF_CTRL = 4'h0;
  localparam logic [3:0] OFF_LOAD = 4'h4;
  localparam logic [3:0] OFF_CMP  = 4'h8;
  localparam logic [3:0] OFF_PRE  = 4'hC;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;
  localparam int CTRL_IRQ_CLR     = 3;

  // Stored CTRL state; irq_clear is a write-only strobe and never held here.
  typedef struct packed {
    logic auto_reload;
    logic irq_en;
    logic enable;
  } ctrl_t;

  function automatic ctrl_t ctrl_image(logic [2:0] w);
    ctrl_t c;
    c.enable      = w[CTRL_EN];
    c.irq_en      = w[CTRL_IRQ_EN];
    c.auto_reload = w[CTRL_AUTO_RELOAD];
    return c;
  endfunction

endpackage

// File: rtl/t03_hwclk_prescaler.sv
// Prescale divider: emits one tick every (prescale+1) enabled cycles.
module t03_hwclk_prescaler
  import t03_hwclk_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  assign tick = enable && (count == prescale);

  // Count sits at 0 while disabled so re-enabling starts a full period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/t03_hardwareclk_mmio_wr.sv
// CPU write port of the hardware clock: register file, req/ack handshake,
// free-running 32-bit counter and compare-match interrupt.
module t03_hardwareclk_mmio_wr
  import t03_hwclk_pkg::*;
#(
  parameter int                    ADDR_W       = 4,
  parameter int                    PRESCALE_W   = 16,
  parameter logic [PRESCALE_W-1:0] RST_PRESCALE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              ack,
  output logic              err,
  output logic [31:0]       new_counter,
  output logic              irq
);

  ctrl_t                 ctrl;
  logic [31:0]           load_val;
  logic [31:0]           cmp_val;
  logic [PRESCALE_W-1:0] pre_val;
  logic                  irq_pending;

  logic accept;
  logic unmapped;
  logic hit_ctrl, hit_load, hit_cmp, hit_pre;
  logic wr_ctrl, wr_load, wr_cmp, wr_pre;
  logic tick;
  logic match;

  // ack blocks re-acceptance of a request the CPU is still holding.
  assign accept = cpu_wen && !ack;

  // All four offsets are word aligned, so any address with [1:0]!=0 misses.
  always_comb begin
    hit_ctrl = 1'b0;
    hit_load = 1'b0;
    hit_cmp  = 1'b0;
    hit_pre  = 1'b0;
    case (cpu_addr)
      ADDR_W'(OFF_CTRL): hit_ctrl = 1'b1;
      ADDR_W'(OFF_LOAD): hit_load = 1'b1;
      ADDR_W'(OFF_CMP):  hit_cmp  = 1'b1;
      ADDR_W'(OFF_PRE):  hit_pre  = 1'b1;
      default: ;
    endcase
  end

  assign unmapped = !(hit_ctrl || hit_load || hit_cmp || hit_pre);
  assign wr_ctrl  = accept && hit_ctrl;
  assign wr_load  = accept && hit_load;
  assign wr_cmp   = accept && hit_cmp;
  assign wr_pre   = accept && hit_pre;

  t03_hwclk_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .enable   (ctrl.enable),
    .prescale (pre_val),
    .clear    (wr_load || wr_pre),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack      <= 1'b0;
      err      <= 1'b0;
      ctrl     <= '0;
      load_val <= '0;
      cmp_val  <= '1;
      pre_val  <= RST_PRESCALE;
    end else begin
      ack <= accept;
      err <= accept && unmapped;
      if (wr_ctrl) ctrl     <= ctrl_image(cpu_wdata[2:0]);
      if (wr_load) load_val <= cpu_wdata;
      if (wr_cmp)  cmp_val  <= cpu_wdata;
      if (wr_pre)  pre_val  <= cpu_wdata[PRESCALE_W-1:0];
    end
  end

  assign match = tick && (new_counter == cmp_val);

  // A LOAD write overrides the tick entirely, including its compare check;
  // a match set beats a simultaneous irq_clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      new_counter <= '0;
      irq_pending <= 1'b0;
    end else begin
      if (wr_load) begin
        new_counter <= cpu_wdata;
      end else if (tick) begin
        new_counter <= (match && ctrl.auto_reload) ? load_val : new_counter + 32'd1;
      end
      if (match && !wr_load) begin
        irq_pending <= 1'b1;
      end else if (wr_ctrl && cpu_wdata[CTRL_IRQ_CLR]) begin
        irq_pending <= 1'b0;
      end
    end
  end

  assign irq = irq_pending && ctrl.irq_en;

endmodule

// File: tb/tb_t03_hardwareclk_mmio_wr.sv
// Bench for the hardware clock write side: directed scenarios followed by
// randomized traffic compared against a cycle model of the register rules.
module tb_t03_hardwareclk_mmio_wr;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wen;
  logic [3:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        ack;
  logic        err;
  logic [31:0] new_counter;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  t03_hardwareclk_mmio_wr #(
    .ADDR_W(4),
    .PRESCALE_W(16),
    .RST_PRESCALE(16'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_wen     (cpu_wen),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .ack         (ack),
    .err         (err),
    .new_counter (new_counter),
    .irq         (irq)
  );

  // Reference model: register state plus "cycles since last tick" phase.
  logic        m_en, m_ien, m_ar, m_pend, m_ack, m_err;
  logic [31:0] m_load, m_cmp, m_cnt;
  int          m_pre, m_phase;
  logic        t_take, t_bad, t_tick, t_set, t_clr;
  logic [31:0] t_nc;
  int          t_np;

  always @(posedge clk) begin
    if (!rst) begin
      m_en = 0; m_ien = 0; m_ar = 0; m_pend = 0; m_ack = 0; m_err = 0;
      m_load = 0; m_cmp = 32'hFFFF_FFFF; m_cnt = 0; m_pre = 0; m_phase = 0;
    end else begin
      t_take = cpu_wen && !m_ack;
      t_bad  = t_take && (cpu_addr % 4 != 0);
      t_tick = m_en && (m_phase == m_pre);
      t_set  = 0;
      t_clr  = 0;
      t_nc   = m_cnt;
      t_np   = !m_en ? 0 : (t_tick ? 0 : m_phase + 1);
      if (t_tick) begin
        if (m_cnt == m_cmp) begin
          t_set = 1;
          t_nc  = m_ar ? m_load : m_cnt + 32'd1;
        end else begin
          t_nc = m_cnt + 32'd1;
        end
      end
      if (t_take && !t_bad) begin
        case (cpu_addr)
          4'h0: begin
            m_en = cpu_wdata[0]; m_ien = cpu_wdata[1]; m_ar = cpu_wdata[2];
            t_clr = cpu_wdata[3];
          end
          4'h4: begin m_load = cpu_wdata; t_nc = cpu_wdata; t_np = 0; t_set = 0; end
          4'h8: m_cmp = cpu_wdata;
          default: begin m_pre = int'(cpu_wdata[15:0]); t_np = 0; end
        endcase
      end
      if (t_set) m_pend = 1;
      else if (t_clr) m_pend = 0;
      m_cnt   = t_nc;
      m_phase = t_np;
      m_ack   = t_take;
      m_err   = t_bad;
    end
  end

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, output logic e);
    cpu_addr = a; cpu_wdata = d; cpu_wen = 1'b1;
    e = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin
        e = err;
        cpu_wen = 1'b0;
        return;
      end
    end
    cpu_wen = 1'b0;
    checks++; failures++;
    $display("FAIL write_timeout addr=%h: no ack seen, required ack within 8 cycles", a);
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (new_counter !== 32'h0) begin failures++; $display("FAIL reset_counter got=%h want=0", new_counter); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (new_counter !== 32'h0) begin failures++; $display("FAIL reset_idle_counter cyc=%0d got=%h want=0", i, new_counter); end
    end
  endtask

  task automatic test_handshake();
    logic       e;
    logic [3:0] ack_seen;
    logic [31:0] cnt0;
    cpu_addr = 4'h4; cpu_wdata = 32'h10; cpu_wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ack_seen[i] = ack;
      if (i == 0) cnt0 = new_counter;
    end
    cpu_wen = 1'b0;
    // A request still held after ack falls is a fresh write one cycle later.
    checks++; if (ack_seen !== 4'b0101) begin failures++; $display("FAIL hs_ack_pattern got=%b want=0101", ack_seen); end
    checks++; if (cnt0 !== 32'h10) begin failures++; $display("FAIL hs_load_on_ack got=%h want=00000010", cnt0); end
    do_write(4'h6, 32'hDEAD_BEEF, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL hs_unaligned_err got=%b want=1", e); end
    checks++; if (new_counter !== 32'h10) begin failures++; $display("FAIL hs_unaligned_nochange got=%h want=00000010", new_counter); end
    do_write(4'h4, 32'h10, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL hs_mapped_err got=%b want=0", e); end
  endtask

  task automatic test_prescaler();
    logic e;
    do_write(4'hC, 32'd3, e);
    do_write(4'h0, 32'h1, e);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) begin
        checks++; if (new_counter !== 32'h10) begin failures++; $display("FAIL pre_hold got=%h want=00000010", new_counter); end
      end
      if (i == 4) begin
        checks++; if (new_counter !== 32'h11) begin failures++; $display("FAIL pre_first_tick got=%h want=00000011", new_counter); end
      end
      if (i == 8) begin
        checks++; if (new_counter !== 32'h12) begin failures++; $display("FAIL pre_second_tick got=%h want=00000012", new_counter); end
      end
    end
  endtask

  task automatic test_compare_reload();
    logic e;
    logic [31:0] exp_cnt [7] = '{5, 6, 7, 5, 6, 7, 5};
    logic        exp_irq [7] = '{0, 0, 0, 1, 1, 1, 1};
    do_write(4'h0, 32'h0, e);
    do_write(4'h4, 32'd5, e);
    do_write(4'h8, 32'd7, e);
    do_write(4'hC, 32'd0, e);
    do_write(4'h0, 32'h7, e);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (new_counter !== exp_cnt[i]) begin failures++; $display("FAIL cmp_seq[%0d] got=%h want=%h", i, new_counter, exp_cnt[i]); end
      checks++; if (irq !== exp_irq[i]) begin failures++; $display("FAIL cmp_irq[%0d] got=%b want=%b", i, irq, exp_irq[i]); end
    end
    // Clear on a non-match edge (counter 5 going to 6).
    do_write(4'h0, 32'hF, e);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clr_irq got=%b want=0", irq); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (irq !== 1'b1 || new_counter !== 32'd5) begin failures++; $display("FAIL clr_reraise irq=%b cnt=%h want irq=1 cnt=5", irq, new_counter); end
    @(negedge clk);
    @(negedge clk);
    // Clear lands on the match edge (counter 7): the set wins.
    do_write(4'h0, 32'hF, e);
    checks++; if (irq !== 1'b1 || new_counter !== 32'd5) begin failures++; $display("FAIL clr_vs_match irq=%b cnt=%h want irq=1 cnt=5", irq, new_counter); end
  endtask

  task automatic test_wrap();
    logic e;
    logic [31:0] exp_cnt [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1, 2, 3, 4};
    do_write(4'h0, 32'h8, e);
    do_write(4'h4, 32'hFFFF_FFFE, e);
    do_write(4'h8, 32'd3, e);
    do_write(4'h0, 32'h1, e);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (new_counter !== exp_cnt[i]) begin failures++; $display("FAIL wrap_seq[%0d] got=%h want=%h", i, new_counter, exp_cnt[i]); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL wrap_irq_gated[%0d] got=%b want=0", i, irq); end
    end
    // Enabling irq while disabling the counter exposes the latched pending bit.
    do_write(4'h0, 32'h2, e);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL wrap_pending_latched got=%b want=1", irq); end
    repeat (5) @(negedge clk);
    checks++; if (new_counter !== 32'd5) begin failures++; $display("FAIL freeze got=%h want=00000005", new_counter); end
  endtask

  task automatic test_collision();
    logic e;
    do_write(4'h8, 32'hFFFF_FFFF, e);
    do_write(4'h0, 32'h1, e);
    do_write(4'h4, 32'h1000, e);
    checks++; if (new_counter !== 32'h1000) begin failures++; $display("FAIL load_vs_tick got=%h want=00001000", new_counter); end
    @(negedge clk);
    checks++; if (new_counter !== 32'h1001) begin failures++; $display("FAIL load_then_tick got=%h want=00001001", new_counter); end
  endtask

  task automatic test_mid_reset();
    logic e;
    cpu_addr = 4'h4; cpu_wdata = 32'h55; cpu_wen = 1'b1; rst = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL mrst_ack ack=%b err=%b want 0 0", ack, err); end
    checks++; if (new_counter !== 32'h0 || irq !== 1'b0) begin failures++; $display("FAIL mrst_state cnt=%h irq=%b want 0 0", new_counter, irq); end
    @(negedge clk);
    cpu_wen = 1'b0; rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (ack !== 1'b0 || new_counter !== 32'h0) begin failures++; $display("FAIL mrst_after[%0d] ack=%b cnt=%h want 0 0", i, ack, new_counter); end
    end
    do_write(4'h0, 32'h2, e);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mrst_pending got=%b want=0", irq); end
    do_write(4'h8, 32'd2, e);
    do_write(4'h0, 32'h7, e);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (new_counter !== ((i == 3) ? 32'd0 : 32'(i))) begin failures++; $display("FAIL mrst_regs[%0d] got=%h", i, new_counter); end
    end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mrst_match_irq got=%b want=1", irq); end
  endtask

  task automatic test_random();
    int sel;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom % 250) != 0;
      cpu_wen = ($urandom % 3) == 0;
      sel = $urandom % 6;
      case (sel)
        0: begin cpu_addr = 4'h0; cpu_wdata = $urandom; end
        1: begin cpu_addr = 4'h4; cpu_wdata = ($urandom % 2) ? $urandom : 32'hFFFF_FFF0 + 32'($urandom % 16); end
        2, 3: begin cpu_addr = 4'h8; cpu_wdata = m_cnt + 32'($urandom_range(0, 8)); end
        4: begin cpu_addr = 4'hC; cpu_wdata = 32'($urandom_range(0, 3)); end
        default: begin cpu_addr = 4'($urandom) | 4'h1; cpu_wdata = $urandom; end
      endcase
      @(negedge clk);
      checks++; if (new_counter !== m_cnt) begin failures++; $display("FAIL rnd_counter n=%0d got=%h want=%h", n, new_counter, m_cnt); end
      checks++; if (ack !== m_ack || err !== m_err) begin failures++; $display("FAIL rnd_ack n=%0d got=%b%b want=%b%b", n, ack, err, m_ack, m_err); end
      checks++; if (irq !== (m_pend && m_ien)) begin failures++; $display("FAIL rnd_irq n=%0d got=%b want=%b", n, irq, m_pend && m_ien); end
    end
    cpu_wen = 1'b0; rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_handshake();
    test_prescaler();
    test_compare_reload();
    test_wrap();
    test_collision();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
